md_unit_ctrl: RTL



---
 rtl/md_unit_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mult/div sequencer that owns HI/LO.
// It also raises a stall request for D-stage mult/div ops that would collide with an in-flight operation.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult,
  input  logic        multu,
  input  logic        div,
  input  logic        divu,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo, abs_a, abs_b, dvs, q, r, quo, rem;
  logic [63:0] ext_a, ext_b, prod, res;
  logic        pend_wr, is_div, neg_a, neg_b, b_nz;
  assign busy = cnt != 4'd0;
  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    is_div = div | divu;
    start  = (mult | multu | is_div) & ~busy;
    stall  = d_md_use & (start | busy);
    md_out = mfhi ? hi : mflo ? lo : 32'd0;
    ext_a  = {{32{mult & rs_val[31]}}, rs_val};
    ext_b  = {{32{mult & rt_val[31]}}, rt_val};
    prod   = ext_a * ext_b;
    neg_a  = div & rs_val[31];
    neg_b  = div & rt_val[31];
    abs_a  = neg_a ? -rs_val : rs_val;
    abs_b  = neg_b ? -rt_val : rt_val;
    b_nz   = |rt_val;
    dvs    = b_nz ? abs_b : 32'd1;
    q      = abs_a / dvs;
    r      = abs_a % dvs;
    quo    = (neg_a ^ neg_b) ? -q : q;
    rem    = neg_a ? -r : r;
    res    = is_div ? {rem, quo} : prod;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (start) begin
      cnt     <= is_div ? DC : MC;
      pend_hi <= res[63:32];
      pend_lo <= res[31:0];
      pend_wr <= ~is_div | b_nz;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (mthi) hi <= rs_val;
      if (mtlo) lo <= rs_val;
    end
  end
endmodule
